mpred256_serial: RTL and testbench
==================================

Name: mpred256_serial

Overview:
- Downstream stage of the 256-bit multi-precision adder.
- Consumes the 257-bit sum s (a + b, with a, b < P) and produces r = s mod P by one conditional subtraction.
- The subtraction s − P runs word-serially, 32 bits per cycle with a borrow chain, so it shares the adder's area/latency trade-off.
- The result feeds the next modular-arithmetic stage through a load/start/ready handshake.

Parameters:
- P, 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF, modulus (NIST P-256 prime).
- WORD_W, 32, serial datapath word width. Must divide 256.
- NWORDS, 256/WORD_W (8), number of serial word steps.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- s_in  input  257  sum from adder; bit 256 is the carry.
- load  input  1  capture s_in into the internal register s (accepted in IDLE only).
- start  input  1  begin reduction of the captured s (accepted in IDLE only).
- r_out  output  256  reduced result, held until the next result.
- ready  output  1  one-cycle pulse when r_out is valid.
- busy  output  1  high while a reduction is in progress.

Behaviour:
- Reset: asynchronous on RST_N low. Clears state to IDLE, s = 0, the difference register d = 0, borrow = 0, word index = 0, r_out = 0, ready = 0, busy = 0.
- Reset asserted mid-operation aborts immediately. No ready pulse is produced for the aborted operation.
- States:
  - IDLE → SUB on start.
  - SUB → SUB while word index < NWORDS−1.
  - SUB → SEL when the last word is done.
  - SEL → IDLE unconditionally.
- IDLE:
  - load=1: s <= s_in.
  - start=1 and load=0: word index <= 0, borrow <= 0, busy <= 1, go to SUB.
  - load=1 and start=1 in the same cycle: load wins and start is ignored. The caller must re-issue start.
- SUB, each cycle for word i:
  - {borrow_out, d_i} = s[i*W +: W] − P[i*W +: W] − borrow.
  - Store d_i into d[i*W +: W], borrow <= borrow_out, index++.
- SEL:
  - Keep the difference when s[256]=1, or when borrow=0 (meaning s ≥ P): r_out <= d (mod 2^256).
  - Otherwise r_out <= s[255:0].
  - ready <= 1, busy <= 0, go to IDLE.
- ready clears on the following edge. It is never high for two consecutive cycles.
- Timing with the default NWORDS=8:
  - start sampled at edge 0.
  - Words 0..7 complete at edges 1..8.
  - r_out updates and ready rises at edge 9.
  - ready falls at edge 10.
  - busy is high from edge 0 up to edge 9.
- load and start are ignored while busy=1. The internal s is not overwritten mid-operation.
- Input contract is s < 2P. For s ≥ 2P the output is still deterministic: r = (s − P) mod 2^256. No error flag.
- Back-to-back operation: a new load is accepted in the cycle ready is high, since the state is already IDLE.

Optional Feature:
- Macro MPRED_PARALLEL_EN.
- Defined: SUB performs the full 257-bit s − P in a single cycle. Timing becomes start at edge 0, SUB at edge 1, r_out/ready at edge 2. Ports and results are identical. WORD_W and NWORDS are unused.
- Undefined: word-serial behaviour as specified above.

Test Plan:
- Reset, load s_in=0, start → ready at edge 9, r_out=0, busy observed high for edges 0..8.
- Load s_in=P, start → r_out=0.
- Load s_in=P−1, start → r_out=P−1, because of the borrow path.
- Load s_in=2P−1, start → r_out=P−1.
- Load s_in = 257'h1_0000…0 (only bit 256 set), start → r_out = 256'h00000000FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF000000000000000000000001.
- Boundary events:
  - start held high during SUB does not restart; ready pulses exactly once.
  - load+start in the same IDLE cycle → no operation, s updated.
  - RST_N low at edge 4 of an operation → ready, busy and r_out all 0 immediately, and no ready pulse thereafter.

Source files
------------

// File: rtl/mpred256_serial.sv
// mpred256_serial: reduces a 257-bit adder sum modulo P with one conditional subtraction.
// The subtraction is word-serial by default; define MPRED_PARALLEL_EN for a single-cycle 257-bit subtract.
`default_nettype none

module mpred256_serial #(
   parameter logic [255:0] P      = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF,
   parameter int           WORD_W = 32,
   parameter int           NWORDS = 256 / WORD_W
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic [256:0] s_in,
   input  logic         load,
   input  logic         start,
   output logic [255:0] r_out,
   output logic         ready,
   output logic         busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_SEL  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_next_state;
   logic [256:0]   r_s;
   logic [255:0]   r_d;
   logic           r_borrow;
   logic [255:0]   r_res;
   logic           r_ready;
   logic           r_busy;
   logic           w_accept_load;
   logic           w_accept_start;

`ifdef MPRED_PARALLEL_EN
   logic [256:0]   w_full_diff;

   assign w_full_diff = {1'b0, r_s[255:0]} - {1'b0, P};
`else
   localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   logic [IDX_W-1:0]  r_idx;
   logic [WORD_W-1:0] w_s_word;
   logic [WORD_W-1:0] w_p_word;
   logic [WORD_W:0]   w_word_diff;
   logic              w_last_word;

   assign w_s_word    = r_s[r_idx*WORD_W +: WORD_W];
   assign w_p_word    = P[r_idx*WORD_W +: WORD_W];
   // Top bit of the widened difference is the borrow out of this word.
   assign w_word_diff = {1'b0, w_s_word} - {1'b0, w_p_word} - {{WORD_W{1'b0}}, r_borrow};
   assign w_last_word = (r_idx == IDX_W'(NWORDS - 1));
`endif

   always_comb begin
      w_next_state   = r_state;
      w_accept_load  = 1'b0;
      w_accept_start = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A simultaneous load takes priority; the start is dropped.
            if (load) begin
               w_accept_load = 1'b1;
            end else if (start) begin
               w_accept_start = 1'b1;
               w_next_state   = ST_SUB;
            end
         end
         ST_SUB: begin
`ifdef MPRED_PARALLEL_EN
            w_next_state = ST_SEL;
`else
            if (w_last_word) begin
               w_next_state = ST_SEL;
            end
`endif
         end
         ST_SEL:  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state  <= ST_IDLE;
         r_s      <= '0;
         r_d      <= '0;
         r_borrow <= 1'b0;
         r_res    <= '0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
`ifndef MPRED_PARALLEL_EN
         r_idx    <= '0;
`endif
      end else begin
         r_state <= w_next_state;
         r_ready <= 1'b0;
         if (w_accept_load) begin
            r_s <= s_in;
         end
         if (w_accept_start) begin
            r_borrow <= 1'b0;
            r_busy   <= 1'b1;
`ifndef MPRED_PARALLEL_EN
            r_idx    <= '0;
`endif
         end
         if (r_state == ST_SUB) begin
`ifdef MPRED_PARALLEL_EN
            r_d      <= w_full_diff[255:0];
            r_borrow <= w_full_diff[256];
`else
            r_d[r_idx*WORD_W +: WORD_W] <= w_word_diff[WORD_W-1:0];
            r_borrow <= w_word_diff[WORD_W];
            r_idx    <= r_idx + IDX_W'(1);
`endif
         end
         if (r_state == ST_SEL) begin
            // A carry into bit 256 or no final borrow both mean s >= P.
            r_res   <= (r_s[256] || !r_borrow) ? r_d : r_s[255:0];
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
         end
      end
   end

   assign r_out = r_res;
   assign ready = r_ready;
   assign busy  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mpred256_serial.sv
// tb_mpred256_serial: directed-vector bench for mpred256_serial with immediate-assertion checks.
`default_nettype none

module tb_mpred256_serial;

   localparam logic [255:0] P = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
`ifdef MPRED_PARALLEL_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 9;
`endif

   logic         CLK = 1'b0;
   logic         RST_N = 1'b1;
   logic [256:0] s_in = '0;
   logic         load = 1'b0;
   logic         start = 1'b0;
   logic [255:0] r_out;
   logic         ready;
   logic         busy;

   int n_pass  = 0;
   int n_total = 0;

   mpred256_serial dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .s_in  (s_in),
      .load  (load),
      .start (start),
      .r_out (r_out),
      .ready (ready),
      .busy  (busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h required %h", tag, obs, exp);
   endtask

   task automatic do_load(input logic [256:0] v);
      @(negedge CLK);
      s_in = v;
      load = 1'b1;
      @(negedge CLK);
      load = 1'b0;
   endtask

   // Pulses (or holds) start, waits a bounded time for ready, then watches for stray pulses.
   task automatic run_op(input string tag, input logic [255:0] exp, input bit hold_start, input bit busy_load);
      int lat;
      int pulses;
      bit busy_ok;
      bit done;
      logic busy_at_ready;
      lat = 0;
      pulses = 0;
      busy_ok = 1'b1;
      done = 1'b0;
      busy_at_ready = 1'bx;
      @(negedge CLK);
      start = 1'b1;
      @(posedge CLK);
      while (!done && lat < LAT + 10) begin
         @(negedge CLK);
         if (!hold_start) start = 1'b0;
         if (ready) begin
            done = 1'b1;
            pulses++;
            start = 1'b0;
            load = 1'b0;
            busy_at_ready = busy;
         end else begin
            if (!busy) busy_ok = 1'b0;
            if (busy_load && lat == 2) begin
               s_in = '1;
               load = 1'b1;
            end else begin
               load = 1'b0;
            end
            @(posedge CLK);
            lat++;
         end
      end
      start = 1'b0;
      load = 1'b0;
      chk({tag, " latency"}, 257'(lat), 257'(LAT));
      chk({tag, " busy during op"}, 257'(busy_ok), 257'd1);
      chk({tag, " r_out"}, {1'b0, r_out}, {1'b0, exp});
      chk({tag, " busy at ready"}, 257'(busy_at_ready), 257'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         if (ready) pulses++;
      end
      chk({tag, " ready pulses"}, 257'(pulses), 257'd1);
   endtask

   initial begin
      int pulses;
      int busy_seen;

      #2 RST_N = 1'b0;
      #20;
      chk("reset r_out", {1'b0, r_out}, 257'd0);
      chk("reset ready", 257'(ready), 257'd0);
      chk("reset busy", 257'(busy), 257'd0);
      @(negedge CLK);
      RST_N = 1'b1;

      do_load(257'd0);
      run_op("zero", 256'd0, 1'b0, 1'b0);

      do_load({1'b0, P});
      run_op("s=P", 256'd0, 1'b0, 1'b0);

      do_load({1'b0, P - 256'd1});
      run_op("s=P-1", P - 256'd1, 1'b0, 1'b0);

      // Load attempted mid-operation must not disturb the captured operand.
      do_load({1'b0, P} + {1'b0, P} - 257'd1);
      run_op("s=2P-1 busy load", P - 256'd1, 1'b0, 1'b1);

      do_load({1'b1, 256'd0});
      run_op("s=2^256", 256'h00000000FFFFFFFEFFFFFFFFFFFFFFFFFFFFFFFF000000000000000000000001, 1'b0, 1'b0);

      @(negedge CLK);
      s_in = 257'd5;
      load = 1'b1;
      start = 1'b1;
      @(negedge CLK);
      load = 1'b0;
      start = 1'b0;
      pulses = 0;
      busy_seen = 0;
      for (int i = 0; i < LAT + 4; i++) begin
         @(negedge CLK);
         if (ready) pulses++;
         if (busy) busy_seen++;
      end
      chk("load+start no ready", 257'(pulses), 257'd0);
      chk("load+start no busy", 257'(busy_seen), 257'd0);
      run_op("load+start s updated", 256'd5, 1'b0, 1'b0);

      do_load({1'b0, P} + 257'd7);
      run_op("held start", 256'd7, 1'b1, 1'b0);

      do_load({1'b1, 256'd0});
      @(negedge CLK);
      start = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      start = 1'b0;
      repeat (4) @(posedge CLK);
      #2 RST_N = 1'b0;
      #1;
      chk("abort r_out", {1'b0, r_out}, 257'd0);
      chk("abort ready", 257'(ready), 257'd0);
      chk("abort busy", 257'(busy), 257'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      pulses = 0;
      busy_seen = 0;
      for (int i = 0; i < LAT + 6; i++) begin
         @(negedge CLK);
         if (ready) pulses++;
         if (busy) busy_seen++;
      end
      chk("abort no ready", 257'(pulses), 257'd0);
      chk("abort no busy", 257'(busy_seen), 257'd0);

      do_load({1'b0, P} + 257'd3);
      run_op("after abort", 256'd3, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
